// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use stall, MUL/DIV hold and taken-branch flush control.
// Drives PC / IF-ID / ID-EX enables from ID decode and EX-stage status.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   ID_rs, ID_rt          source registers of the ID instruction
//   ID_UsesRs/ID_UsesRt   ID instruction actually reads rs / rt
//   ID_IsMulDiv           ID instruction is a multi-cycle MUL/DIV
//   EX_MemRead/RegWrite   EX instruction is a load / writes a register
//   EX_WriteRegister      EX destination register
//   EX_BranchTaken        branch/jump in EX resolved taken
//   PCWrite, IFID_Write   update enables (1 = advance)
//   IFID_Flush            IF/ID loads a NOP
//   IDEX_Bubble           ID/EX loads a NOP
//   EX_Hold, MD_Busy      MUL/DIV occupying EX, pipeline held
//   StallCount/FlushCount optional statistics (HAZ_STATS_EN)
//
// Optional feature macro: HAZ_STATS_EN adds 32-bit stall/flush counters.

module hazard_stall_unit #(
    parameter int MD_LATENCY = 4,
    parameter int REG_AW     = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] ID_rs,
    input  logic [REG_AW-1:0] ID_rt,
    input  logic              ID_UsesRs,
    input  logic              ID_UsesRt,
    input  logic              ID_IsMulDiv,
    input  logic              EX_MemRead,
    input  logic              EX_RegWrite,
    input  logic [REG_AW-1:0] EX_WriteRegister,
    input  logic              EX_BranchTaken,
    output logic              PCWrite,
    output logic              IFID_Write,
    output logic              IFID_Flush,
    output logic              IDEX_Bubble,
    output logic              EX_Hold,
    output logic              MD_Busy
`ifdef HAZ_STATS_EN
    ,
    output logic [31:0]       StallCount,
    output logic [31:0]       FlushCount
`endif
);

    localparam int CW = $clog2(MD_LATENCY) + 1;
    localparam logic [CW-1:0] MD_INIT = CW'(MD_LATENCY - 1);
    localparam logic [CW-1:0] MD_ONE  = CW'(1);
    localparam bit MD_MULTI = (MD_LATENCY > 1);

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_md_cnt;
    logic [CW-1:0]   w_md_cnt_nxt;

    logic            w_rs_hit;
    logic            w_rt_hit;
    logic            w_lu_haz;
    logic            w_md_arm;

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign w_rs_hit = ID_UsesRs && (ID_rs == EX_WriteRegister);
    assign w_rt_hit = ID_UsesRt && (ID_rt == EX_WriteRegister);
    assign w_lu_haz = EX_MemRead && EX_RegWrite &&
                      (EX_WriteRegister != '0) &&
                      (w_rs_hit || w_rt_hit);

    // Only a MUL/DIV that actually issues into EX starts the hold;
    // a stalled or wrong-path one must not.
    assign w_md_arm = MD_MULTI && ID_IsMulDiv &&
                      !EX_BranchTaken && !w_lu_haz;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= RUN;
            r_md_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_md_cnt <= w_md_cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt  = r_state;
        w_md_cnt_nxt = r_md_cnt;
        unique case (r_state)
            RUN: begin
                if (w_md_arm) begin
                    w_state_nxt  = MD_WAIT;
                    w_md_cnt_nxt = MD_INIT;
                end
            end
            MD_WAIT: begin
                w_md_cnt_nxt = r_md_cnt - MD_ONE;
                if (r_md_cnt == MD_ONE) begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt  = RUN;
                w_md_cnt_nxt = '0;
            end
        endcase
    end

    // Output logic: MD_WAIT dominates, then branch flush, then load-use
    always_comb begin
        PCWrite     = 1'b1;
        IFID_Write  = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Bubble = 1'b0;
        EX_Hold     = 1'b0;
        MD_Busy     = 1'b0;
        unique case (r_state)
            MD_WAIT: begin
                PCWrite    = 1'b0;
                IFID_Write = 1'b0;
                EX_Hold    = 1'b1;
                MD_Busy    = 1'b1;
            end
            RUN: begin
                if (EX_BranchTaken) begin
                    IFID_Flush  = 1'b1;
                    IDEX_Bubble = 1'b1;
                end else if (w_lu_haz) begin
                    PCWrite     = 1'b0;
                    IFID_Write  = 1'b0;
                    IDEX_Bubble = 1'b1;
                end
            end
            default: begin
                PCWrite    = 1'b1;
                IFID_Write = 1'b1;
            end
        endcase
    end

`ifdef HAZ_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!PCWrite) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (IFID_Flush) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign StallCount = r_stall_cnt;
    assign FlushCount = r_flush_cnt;
`endif

endmodule
